// File: rtl/bitmap2_fetch.sv
`timescale 1ns/1ps
// bitmap2_fetch: turns the VGA raster position into bitmap memory reads and
// a 4-bit palette index. Each memory byte holds two pixels: the high nibble
// is the even pixel and the low nibble is the odd pixel. Each bitmap pixel
// is drawn as a 2^SCALE_LOG2 square on screen.
//
// Ports
//   i_clk, i_rst_n      pixel clock, asynchronous active-low reset
//   i_active, i_x, i_y  raster timing inputs
//   o_rd_en, o_rd_addr  synchronous memory read strobe and byte address
//   i_rd_data           memory byte, valid one cycle after o_rd_en
//   o_index, o_active   palette index and display enable, 3 cycles after
//                       the raster inputs
//
// Build option
//   BITMAP2_FETCH_READ_SKIP_EN  defined: a read is issued only when the byte
//   address changes or on the first in-image cycle of a row. Otherwise the
//   held byte is reused. o_index is the same as in the default build.
module bitmap2_fetch #(
   parameter int unsigned IMG_W      = 160,
   parameter int unsigned IMG_H      = 120,
   parameter int unsigned SCALE_LOG2 = 2,
   parameter logic [3:0]  BG_INDEX   = 4'd0,
   parameter int unsigned AW         = 14
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_active,
   input  logic [9:0]    i_x,
   input  logic [9:0]    i_y,
   output logic          o_rd_en,
   output logic [AW-1:0] o_rd_addr,
   input  logic [7:0]    i_rd_data,
   output logic [3:0]    o_index,
   output logic          o_active
);

   localparam int unsigned PW      = AW + 1;
   localparam logic [9:0]  Y_MASK  = 10'((1 << SCALE_LOG2) - 1);
   localparam logic [PW-1:0] IMG_W_P = PW'(IMG_W);

   // Position decode
   logic [9:0]    bx_c, by_c;
   logic          in_img_c, origin_c, row_step_c, locked_c, req_c, rd_c;
   logic [PW-1:0] base_c, pix_c;
   logic [AW-1:0] addr_c;

   // State
   logic [PW-1:0] row_base_q, row_base_d;
   logic          lock_q, lock_d;
   logic          rd_en_q, rd_en_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic          s1_act_q, s1_act_d, s1_show_q, s1_show_d;
   logic          s1_bg_q, s1_bg_d, s1_odd_q, s1_odd_d;
   logic          s2_act_q, s2_act_d, s2_show_q, s2_show_d;
   logic          s2_bg_q, s2_bg_d, s2_odd_q, s2_odd_d;
   logic [3:0]    index_q, index_d;
   logic          active_q, active_d;
   logic [7:0]    data_c;

`ifdef BITMAP2_FETCH_READ_SKIP_EN
   logic          seen_q, seen_d;
   logic [AW-1:0] last_q, last_d;
   logic          s2_rd_q, s2_rd_d;
   logic [7:0]    byte_q, byte_d;
`endif

   assign bx_c       = i_x >> SCALE_LOG2;
   assign by_c       = i_y >> SCALE_LOG2;
   assign in_img_c   = (32'(bx_c) < IMG_W) && (32'(by_c) < IMG_H);
   assign origin_c   = (i_x == 10'd0) && (i_y == 10'd0);
   assign row_step_c = (i_x == 10'd0) && ((i_y & Y_MASK) == 10'd0) && (i_y != 10'd0);
   // Lock takes effect on the (0,0) cycle itself so that pixel is drawn.
   assign locked_c   = lock_q | origin_c;
   assign req_c      = i_active & in_img_c & locked_c;

   // Row base as seen by the current pixel: the x==0 update is folded in
   // combinationally so the first pixel of a new bitmap row is correct.
   always_comb begin
      base_c = row_base_q;
      if (origin_c) begin
         base_c = '0;
      end else if (row_step_c) begin
         base_c = row_base_q + IMG_W_P;
      end
   end

   assign pix_c  = base_c + PW'(bx_c);
   assign addr_c = pix_c[AW:1];

   // Read strobe decision
`ifdef BITMAP2_FETCH_READ_SKIP_EN
   always_comb begin
      rd_c   = req_c & (~(seen_q & (i_x != 10'd0)) | (addr_c != last_q));
      seen_d = seen_q;
      last_d = last_q;
      if (rd_c) begin
         seen_d = 1'b1;
         last_d = addr_c;
      end else if (i_x == 10'd0) begin
         seen_d = 1'b0;
      end
   end
   assign s2_rd_d = rd_en_q;
   assign byte_d  = s2_rd_q ? i_rd_data : byte_q;
   assign data_c  = s2_rd_q ? i_rd_data : byte_q;
`else
   assign rd_c   = req_c;
   assign data_c = i_rd_data;
`endif

   // Next-state for row base, lock and the three pipeline stages
   always_comb begin
      row_base_d = row_base_q;
      lock_d     = lock_q | origin_c;
      if (i_x == 10'd0) begin
         row_base_d = base_c;
      end
      rd_en_d   = rd_c;
      rd_addr_d = addr_c;
      s1_act_d  = i_active;
      s1_show_d = req_c;
      s1_bg_d   = i_active & locked_c & ~in_img_c;
      s1_odd_d  = pix_c[0];
      s2_act_d  = s1_act_q;
      s2_show_d = s1_show_q;
      s2_bg_d   = s1_bg_q;
      s2_odd_d  = s1_odd_q;
      active_d  = s2_act_q;
      index_d   = 4'd0;
      if (s2_show_q) begin
         index_d = s2_odd_q ? data_c[3:0] : data_c[7:4];
      end else if (s2_bg_q) begin
         index_d = BG_INDEX;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         row_base_q <= '0;
         lock_q     <= 1'b0;
         rd_en_q    <= 1'b0;
         rd_addr_q  <= '0;
         s1_act_q   <= 1'b0;
         s1_show_q  <= 1'b0;
         s1_bg_q    <= 1'b0;
         s1_odd_q   <= 1'b0;
         s2_act_q   <= 1'b0;
         s2_show_q  <= 1'b0;
         s2_bg_q    <= 1'b0;
         s2_odd_q   <= 1'b0;
         index_q    <= 4'd0;
         active_q   <= 1'b0;
      end else begin
         row_base_q <= row_base_d;
         lock_q     <= lock_d;
         rd_en_q    <= rd_en_d;
         rd_addr_q  <= rd_addr_d;
         s1_act_q   <= s1_act_d;
         s1_show_q  <= s1_show_d;
         s1_bg_q    <= s1_bg_d;
         s1_odd_q   <= s1_odd_d;
         s2_act_q   <= s2_act_d;
         s2_show_q  <= s2_show_d;
         s2_bg_q    <= s2_bg_d;
         s2_odd_q   <= s2_odd_d;
         index_q    <= index_d;
         active_q   <= active_d;
      end
   end

`ifdef BITMAP2_FETCH_READ_SKIP_EN
   // Read-skip bookkeeping and held byte
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         seen_q  <= 1'b0;
         last_q  <= '0;
         s2_rd_q <= 1'b0;
         byte_q  <= 8'd0;
      end else begin
         seen_q  <= seen_d;
         last_q  <= last_d;
         s2_rd_q <= s2_rd_d;
         byte_q  <= byte_d;
      end
   end
`endif

   assign o_rd_en   = rd_en_q;
   assign o_rd_addr = rd_addr_q;
   assign o_index   = index_q;
   assign o_active  = active_q;

endmodule

// File: tb/tb_bitmap2_fetch.sv
`timescale 1ns/1ps
// Bench for bitmap2_fetch: scans shortened raster rows (x jumps but every
// row visits x==0), with random active drop-outs, a mid-frame reset and a
// random memory image. Expected reads and indices are computed from
// p = by*IMG_W + bx and queued; monitors pop and compare.
module tb_bitmap2_fetch;

   localparam int unsigned AW    = 14;
   localparam int unsigned IMG_W = 160;
   localparam int unsigned IMG_H = 120;
   localparam int unsigned SL    = 2;
   localparam logic [3:0]  BG    = 4'd9;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          act = 1'b0;
   logic [9:0]    x = 10'd1;
   logic [9:0]    y = 10'd1;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;
   logic [3:0]    idx;
   logic          oact;

   always #5 clk = ~clk;

   bitmap2_fetch #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .SCALE_LOG2(SL), .BG_INDEX(BG), .AW(AW)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_active(act), .i_x(x), .i_y(y),
      .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
      .o_index(idx), .o_active(oact)
   );

   // Synchronous memory; returns garbage on cycles with no read.
   logic [7:0] mem [0:(1<<AW)-1];
   always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 8'($urandom);

   typedef struct packed { logic en; logic [AW-1:0] addr; } rd_t;
   typedef struct packed { logic [3:0] idx; logic act; } out_t;
   rd_t  rdq[$];
   out_t outq[$];

   int n_vec = 0;
   int n_err = 0;

   bit            m_lock = 1'b0;
   bit            m_seen = 1'b0;
   logic [AW-1:0] m_last = '0;

   task automatic check(input string name, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, got, exp);
      end
   endtask

   // Reference: direct pixel arithmetic from the raster position.
   task automatic model(input int xv, input int yv, input bit av);
      bit origin, locked, inimg, req, en;
      int bx, by, p;
      logic [AW-1:0] addr;
      logic [7:0] b;
      rd_t r;
      out_t o;
      origin = (xv == 0) && (yv == 0);
      locked = m_lock || origin;
      if (origin) m_lock = 1'b1;
      bx = xv >> SL;
      by = yv >> SL;
      inimg = (bx < int'(IMG_W)) && (by < int'(IMG_H));
      p = by * int'(IMG_W) + bx;
      addr = AW'(p >> 1);
      req = av && inimg && locked;
`ifdef BITMAP2_FETCH_READ_SKIP_EN
      if (xv == 0) m_seen = 1'b0;
      en = req && (!m_seen || addr != m_last);
      if (en) begin
         m_seen = 1'b1;
         m_last = addr;
      end
`else
      en = req;
`endif
      r.en = en;
      r.addr = addr;
      rdq.push_back(r);
      o.act = av;
      if (!av || !locked) o.idx = 4'd0;
      else if (!inimg) o.idx = BG;
      else begin
         b = mem[p >> 1];
         o.idx = (p % 2 == 0) ? b[7:4] : b[3:0];
      end
      outq.push_back(o);
   endtask

   task automatic drive(input int xv, input int yv, input bit av);
      @(posedge clk);
      #1;
      x = 10'(xv);
      y = 10'(yv);
      act = av;
      model(xv, yv, av);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      rdq.delete();
      outq.delete();
      m_lock = 1'b0;
      m_seen = 1'b0;
      m_last = '0;
      #2;
      check("reset o_rd_en", int'(rd_en), 0);
      check("reset o_rd_addr", int'(rd_addr), 0);
      check("reset o_index", int'(idx), 0);
      check("reset o_active", int'(oact), 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitors: read strobe one cycle behind, index three cycles behind.
   always @(negedge clk) begin
      rd_t r;
      out_t o;
      if (rdq.size() >= 2) begin
         r = rdq.pop_front();
         check("o_rd_en", int'(rd_en), int'(r.en));
         if (r.en) check("o_rd_addr", int'(rd_addr), int'(r.addr));
      end
      if (outq.size() >= 4) begin
         o = outq.pop_front();
         check("o_index", int'(idx), int'(o.idx));
         check("o_active", int'(oact), int'(o.act));
      end
   end

   int cols[$];

   task automatic scan(input int y0, input int y1, input int rst_row);
      bit av;
      for (int yy = y0; yy <= y1; yy++) begin
         foreach (cols[i]) begin
            av = (cols[i] < 648) && ($urandom_range(0, 15) != 0);
            drive(cols[i], yy, av);
            if (yy == rst_row && cols[i] == 300) do_reset();
         end
      end
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
      mem[81] = 8'hA5;
      for (int c = 0; c < 24; c++) cols.push_back(c);
      for (int c = 296; c < 304; c++) cols.push_back(c);
      for (int c = 632; c < 656; c++) cols.push_back(c);
      for (int c = 700; c < 704; c++) cols.push_back(c);

      do_reset();
      // Unlocked before the first (0,0): no reads, index 0.
      for (int i = 0; i < 12; i++)
         drive($urandom_range(1, 639), $urandom_range(1, 479), 1'b1);
      // Partial frame with reset at (300,200), then rows stay unlocked.
      scan(0, 215, 200);
      // Full frame after restart, including rows below the image.
      scan(0, 491, -1);
      for (int i = 0; i < 4; i++) drive(1, 1, 1'b0);
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bitmap2_fetch.md
BITMAP2_FETCH -- requirements
Module: bitmap2_fetch

Interface
REQ-001 Parameter IMG_W, default 160, bitmap width in pixels (even).
REQ-002 Parameter IMG_H, default 120, bitmap height in pixels.
REQ-003 Parameter SCALE_LOG2, default 2, each bitmap pixel is drawn as a 2^SCALE_LOG2 square.
REQ-004 Parameter BG_INDEX, default 4'd0, index output for in-display positions outside the bitmap.
REQ-005 Parameter AW, default 14, byte address width.
REQ-006 i_clk  input  1  pixel clock; the only clock.
REQ-007 i_rst_n  input  1  asynchronous active-low reset.
REQ-008 i_active  input  1  display-enable from VGA timing.
REQ-009 i_x  input  10  current column.
REQ-010 i_y  input  10  current row.
REQ-011 o_rd_en  output  1  synchronous bitmap memory read strobe.
REQ-012 o_rd_addr  output  AW  byte address; 2 pixels per byte.
REQ-013 i_rd_data  input  8  memory data, valid 1 cycle after o_rd_en.
REQ-014 o_index  output  4  palette index for the palette stage.
REQ-015 o_active  output  1  i_active delayed to align with o_index.

Function
REQ-016 Bitmap coordinates SHALL be bx = i_x >> SCALE_LOG2, by = i_y >> SCALE_LOG2; in-image when bx < IMG_W and by < IMG_H.
REQ-017 Pixel number p = by*IMG_W + bx SHALL be formed without a multiplier: a registered row base is cleared at (i_x==0, i_y==0) and increased by IMG_W at i_x==0 on each row where i_y[SCALE_LOG2-1:0]==0 and i_y!=0.
REQ-018 o_rd_addr SHALL be p >> 1, registered 1 cycle after the inputs; o_rd_en SHALL be high for that cycle iff i_active and in-image.
REQ-019 Even p SHALL select i_rd_data[7:4]; odd p SHALL select i_rd_data[3:0].
REQ-020 Latency i_x/i_y/i_active to o_index/o_active SHALL be exactly 3 cycles (address reg, memory, output reg).
REQ-021 o_index SHALL be 0 when the delayed i_active is low, BG_INDEX when active and out-of-image, and the selected nibble otherwise.
REQ-022 Row-base arithmetic SHALL be AW+1 bits; no wrap occurs within IMG_W*IMG_H.
REQ-023 An internal lock flag SHALL set at the first (i_x==0, i_y==0); while unlocked o_rd_en=0 and o_index=0.
REQ-024 i_x/i_y changing with i_active low SHALL not disturb the pipeline beyond REQ-017 updates.

Reset
REQ-025 On i_rst_n low, asynchronously: o_rd_en=0, o_rd_addr=0, o_index=0, o_active=0, row base=0, lock=0, all pipeline registers 0.
REQ-026 Reset asserted mid-frame SHALL leave the block unlocked until the next (i_x==0, i_y==0).
REQ-027 Release SHALL take effect on the first i_clk rising edge after deassertion.

Configuration
REQ-028 Macro BITMAP2_FETCH_READ_SKIP_EN.
REQ-029 Defined: o_rd_en SHALL assert only when the byte address differs from the last one read, or on the first in-image cycle of each row; the output stage reuses the held byte; o_index SHALL be bit-identical to the undefined build.
REQ-030 Undefined: o_rd_en follows REQ-018 every in-image active cycle.

Verification
REQ-031 Reset mid-frame at (300,200), release -> o_index=0, o_rd_en=0 until frame restart; after (0,0) normal output.
REQ-032 Locked, inputs (x=8, y=4, active=1), default params -> o_rd_addr=81 after 1 cycle; memory byte 8'hA5 -> o_index=4'hA after 3 cycles.
REQ-033 Inputs (x=12, y=4) -> p=163, o_rd_addr=81, low nibble; byte 8'hA5 -> o_index=4'h5.
REQ-034 IMG_W=128, x=600, y=10, active=1 -> o_rd_en=0, o_index=BG_INDEX after 3 cycles; active=0 -> o_index=0.
REQ-035 Full 640x480 frame, memory byte n = n[7:0] -> every o_index matches a golden model; o_active equals i_active delayed 3.
REQ-036 With BITMAP2_FETCH_READ_SKIP_EN, one full row -> o_rd_en pulses every 8 cycles (80 per row) and o_index identical to the undefined build.
